// File: rtl/mode_exit_requester.sv
// mode_exit_requester: long-press requester for the main-mode handshake, with ack timeout, retries and release lock-out.
module mode_exit_requester #(
  parameter logic [1:0]  OWN_MODE    = 2'b10,
  parameter logic [1:0]  TARGET_MODE = 2'b01,
  parameter int unsigned HOLD_CYCLES = 100_000_000,
  parameter int unsigned ACK_TIMEOUT = 1024,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] current_main_mode,
  input  logic       btn_trigger,
  input  logic       mode_ack,
  output logic       mode_req,
  output logic [1:0] mode_target,
  output logic       busy,
  output logic       error,
  output logic [3:0] hold_progress
);
  localparam int unsigned SEG_CYCLES = HOLD_CYCLES / 16;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int SW = $clog2(SEG_CYCLES) + 1;
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  localparam int RW = $clog2(MAX_RETRY) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] SEG_LAST  = SW'(SEG_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  typedef enum logic [2:0] {IDLE, HOLD, REQ, GAP, WAIT_RELEASE, FAIL} state_t;
  state_t state, state_d;
  logic [HW-1:0] hold_cnt, hold_cnt_d;
  logic [SW-1:0] seg_cnt, seg_cnt_d;
  logic [TW-1:0] tmo_cnt, tmo_cnt_d;
  logic [RW-1:0] retry, retry_d;
  logic [3:0] hold_progress_d;
  logic mode_req_d, busy_d, error_d;
  logic armed, acked, hold_stay, seg_wrap;
  assign armed = current_main_mode == OWN_MODE;
  // A missed ack shows up as the arbiter having already switched modes.
  assign acked = mode_ack || current_main_mode == TARGET_MODE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      seg_cnt       <= '0;
      tmo_cnt       <= '0;
      retry         <= '0;
      mode_req      <= 1'b0;
      mode_target   <= TARGET_MODE;
      busy          <= 1'b0;
      error         <= 1'b0;
      hold_progress <= 4'd0;
    end else begin
      state         <= state_d;
      hold_cnt      <= hold_cnt_d;
      seg_cnt       <= seg_cnt_d;
      tmo_cnt       <= tmo_cnt_d;
      retry         <= retry_d;
      mode_req      <= mode_req_d;
      mode_target   <= TARGET_MODE;
      busy          <= busy_d;
      error         <= error_d;
      hold_progress <= hold_progress_d;
    end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:              state_d = armed && btn_trigger ? HOLD : IDLE;
      HOLD:              state_d = !btn_trigger || !armed ? IDLE : hold_cnt == HOLD_LAST ? REQ : HOLD;
      REQ:               state_d = acked ? WAIT_RELEASE : tmo_cnt != TMO_LAST ? REQ : retry < RETRY_MAX ? GAP : FAIL;
      GAP:               state_d = REQ;
      WAIT_RELEASE, FAIL: state_d = btn_trigger ? state : IDLE;
      default:           state_d = IDLE;
    endcase
  end
  // Outputs and counters are computed from the transition so every output leaves a flop.
  always_comb begin
    hold_stay       = state == HOLD && state_d == HOLD;
    seg_wrap        = seg_cnt == SEG_LAST;
    hold_cnt_d      = hold_stay ? hold_cnt + HW'(1) : '0;
    seg_cnt_d       = hold_stay && !seg_wrap ? seg_cnt + SW'(1) : '0;
    hold_progress_d = !hold_stay ? 4'd0 : seg_wrap && hold_progress != 4'hf ? hold_progress + 4'd1 : hold_progress;
    tmo_cnt_d       = state == REQ && state_d == REQ ? tmo_cnt + TW'(1) : '0;
    retry_d         = state == HOLD ? '0 : state == REQ && state_d == GAP ? retry + RW'(1) : retry;
    mode_req_d      = state_d == REQ;
    busy_d          = state_d != IDLE;
    error_d         = state_d == FAIL || (error && !(state == IDLE && state_d == HOLD));
  end
endmodule

// File: tb/tb_mode_exit_requester.sv
// tb_mode_exit_requester: randomized long-press episodes against a phase/age reference model with a scoreboard.
module tb_mode_exit_requester;
  localparam int H = 32, T = 8, M = 2, SEG = H / 16;
  localparam logic [1:0] OWN = 2'b10, TGT = 2'b01;
  logic clk = 1'b0, reset_n = 1'b1, btn_trigger = 1'b0, mode_ack = 1'b0;
  logic [1:0] current_main_mode = OWN;
  logic mode_req, busy, error;
  logic [1:0] mode_target;
  logic [3:0] hold_progress;
  int checks = 0, errors = 0;
  typedef struct {
    logic req;
    logic [1:0] tgt;
    logic busy;
    logic err;
    logic [3:0] hp;
  } exp_t;
  exp_t q[$];
  mode_exit_requester #(.OWN_MODE(OWN), .TARGET_MODE(TGT), .HOLD_CYCLES(H), .ACK_TIMEOUT(T), .MAX_RETRY(M)) dut (
    .clk(clk), .reset_n(reset_n), .current_main_mode(current_main_mode), .btn_trigger(btn_trigger),
    .mode_ack(mode_ack), .mode_req(mode_req), .mode_target(mode_target), .busy(busy), .error(error),
    .hold_progress(hold_progress));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  // Reference model: phase 0 idle, 1 holding, 2 requesting, 3 waiting for release, 4 gave up.
  // In phase 2, age counts cycles since the first request; each attempt is T high cycles plus one gap cycle.
  int phase = 0, age = 0;
  logic err = 1'b0;
  initial forever begin
    exp_t e;
    @(posedge clk);
    if (!reset_n) begin
      phase = 0; age = 0; err = 1'b0;
    end else
      case (phase)
        0: if (current_main_mode == OWN && btn_trigger) begin phase = 1; age = 0; err = 1'b0; end
        1: if (!btn_trigger || current_main_mode != OWN) phase = 0;
           else if (age == H - 1) begin phase = 2; age = 0; end
           else age++;
        2: if (age % (T + 1) == T) age++;
           else if (mode_ack || current_main_mode == TGT) phase = 3;
           else if (age % (T + 1) == T - 1 && age / (T + 1) == M) begin phase = 4; err = 1'b1; end
           else age++;
        default: if (!btn_trigger) phase = 0;
      endcase
    e.req  = phase == 2 && age % (T + 1) < T;
    e.tgt  = TGT;
    e.busy = phase != 0;
    e.err  = err;
    e.hp   = phase == 1 ? 4'((age / SEG > 15) ? 15 : age / SEG) : 4'd0;
    q.push_back(e);
  end
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      if (!reset_n) begin e.req = 0; e.busy = 0; e.err = 0; e.hp = 0; end
      chk("mode_req", 8'(mode_req), 8'(e.req));
      chk("mode_target", 8'(mode_target), 8'(e.tgt));
      chk("busy", 8'(busy), 8'(e.busy));
      chk("error", 8'(error), 8'(e.err));
      chk("hold_progress", 8'(hold_progress), 8'(e.hp));
    end
  end
  // Acts as the arbiter: acks after ack_at request cycles, or switches mode after sw_at request cycles.
  task automatic episode(input logic [1:0] mode, input int btn_len, input int ack_at, input int sw_at, input int rst_at);
    int cnt = 0, sw_left = 0;
    current_main_mode = mode;
    btn_trigger = 1'b1;
    for (int c = 0; c < btn_len; c++) begin
      @(posedge clk); #2;
      mode_ack = 1'b0;
      cnt = mode_req ? cnt + 1 : 0;
      if (ack_at != 0 && cnt == ack_at) mode_ack = 1'b1;
      else if (!mode_req && $urandom_range(0, 9) == 0) mode_ack = 1'b1;
      if (sw_at != 0 && cnt == sw_at) begin current_main_mode = TGT; sw_left = 3; end
      else if (sw_left > 0) begin sw_left--; if (sw_left == 0) current_main_mode = mode; end
      if (c == rst_at) begin
        reset_n = 1'b0; #1;
        chk("async_mode_req", 8'(mode_req), 8'd0);
        chk("async_busy", 8'(busy), 8'd0);
        chk("async_hold_progress", 8'(hold_progress), 8'd0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        cnt = 0;
      end
    end
    btn_trigger = 1'b0;
    mode_ack = 1'b0;
    repeat ($urandom_range(1, 4)) begin @(posedge clk); #2; end
  endtask
  initial begin
    logic [1:0] m;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    episode(OWN, 45, 3, 0, -1);
    episode(OWN, 20, 0, 0, -1);
    episode(OWN, 70, 0, 0, -1);
    episode(OWN, 50, T, 0, -1);
    episode(OWN, 60, 0, 2, -1);
    episode(OWN, 50, 0, 0, 35);
    episode(TGT, 40, 0, 0, -1);
    for (int i = 0; i < 60; i++) begin
      m = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : OWN;
      episode(m, $urandom_range(1, 90), ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, T + 1),
              ($urandom_range(0, 4) == 0) ? $urandom_range(1, T) : 0,
              ($urandom_range(0, 6) == 0) ? $urandom_range(0, 80) : -1);
    end
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
